// File: rtl/msg_enc_pkg.sv
// Shared constants and FSM state encoding for the LFSR message-encryption sequencer.
package msg_enc_pkg;

  localparam logic [7:0] CFG_PRE  = 8'd61;
  localparam logic [7:0] CFG_TAP  = 8'd62;
  localparam logic [7:0] CFG_SEED = 8'd63;
  localparam logic [7:0] OUT_BASE = 8'd64;
  localparam int         N_OUT    = 64;
  localparam int         MSG_MAX  = 61;
  localparam logic [7:0] PAD      = 8'h20;

  typedef enum logic [2:0] {IDLE, CFG, RUN_RD, RUN_WR, DONE} state_t;

endpackage

// File: rtl/msg_encrypt_seq_if.sv
// Start/Ack handshake plus the single-port data-memory bus driven by the sequencer.
interface msg_encrypt_seq_if;

  logic       Start;
  logic       Ack;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  modport master (
    input  Start, mem_rdata,
    output Ack, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport slave (
    output Start, mem_rdata,
    input  Ack, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

endinterface

// File: rtl/lfsr7_step.sv
// One step of a 7-bit Fibonacci LFSR; combinational, no backpressure.
// parity is the even parity of the current state word.
module lfsr7_step (
  input  logic [6:0] state,
  input  logic [6:0] taps,
  output logic [6:0] next,
  output logic       parity
);

  assign next   = {state[5:0], ^(state & taps)};
  assign parity = ^state;

endmodule

// File: rtl/msg_encrypt_seq.sv
// Reads config + plaintext, writes 64 LFSR-encrypted bytes with parity to mem[64..127].
// Latency 68 + V cycles launch-to-Ack; no backpressure, memory is assumed always ready.
module msg_encrypt_seq
  import msg_enc_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  msg_encrypt_seq_if.master bus
);

  localparam logic [6:0] LAST_IDX = 7'(N_OUT - 1);

  state_t     state;
  logic       armed;
  logic       rd_q;
  logic       wr_q;
  logic       pad_q;
  logic       ack_q;
  logic       busy_q;
  logic [1:0] cnt;
  logic [6:0] idx;
  logic [6:0] taps;
  logic [6:0] lfsr;
  logic [7:0] pre;
  logic [7:0] addr_q;

  logic [6:0] lfsr_nxt;
  logic       lfsr_par;
  logic [6:0] seed_fix;
  logic [6:0] j_nxt;
  logic [8:0] src;
  logic       act_rd;
  logic [7:0] act_addr;
  logic [7:0] byte_in;
  logic [6:0] sym;
  logic       wr_live;

  lfsr7_step u_step (
    .state  (lfsr),
    .taps   (taps),
    .next   (lfsr_nxt),
    .parity (lfsr_par)
  );

  // Next output index and whether it needs a plaintext read first.
  assign j_nxt    = (state == CFG) ? 7'd0 : idx + 7'd1;
  assign src      = {2'b00, j_nxt} - {1'b0, pre};
  assign act_rd   = ~src[8] & (src[7:0] < 8'(MSG_MAX));
  assign act_addr = act_rd ? src[7:0] : OUT_BASE + {1'b0, j_nxt};

  assign seed_fix = (bus.mem_rdata[6:0] == 7'd0) ? 7'h01 : bus.mem_rdata[6:0];

  // Write data is formed from the read response in the write cycle itself.
  assign byte_in = pad_q ? PAD : bus.mem_rdata;
  assign sym     = 7'(byte_in - PAD);
  assign wr_live = wr_q & ~Reset;

  assign bus.mem_wr_en = wr_live;
  assign bus.mem_wdata = wr_live ? {(^sym) ^ lfsr_par, sym ^ lfsr} : 8'h00;
  assign bus.mem_rd_en = rd_q;
  assign bus.mem_addr  = addr_q;
  assign bus.Ack       = ack_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      armed  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      pad_q  <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt    <= 2'd0;
      idx    <= 7'd0;
      taps   <= 7'd0;
      lfsr   <= 7'd0;
      pre    <= 8'd0;
      addr_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            armed <= 1'b1;
          end else if (armed) begin
            state  <= CFG;
            armed  <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= 2'd0;
            rd_q   <= 1'b1;
            addr_q <= CFG_PRE;
          end
        end
        CFG: begin
          cnt <= cnt + 2'd1;
          case (cnt)
            2'd0: addr_q <= CFG_TAP;
            2'd1: begin
              addr_q <= CFG_SEED;
              pre    <= bus.mem_rdata;
            end
            2'd2: begin
              rd_q <= 1'b0;
              taps <= bus.mem_rdata[6:0];
            end
            default: begin
              lfsr   <= seed_fix;
              idx    <= 7'd0;
              state  <= act_rd ? RUN_RD : RUN_WR;
              rd_q   <= act_rd;
              wr_q   <= ~act_rd;
              pad_q  <= ~act_rd;
              addr_q <= act_addr;
            end
          endcase
        end
        RUN_RD: begin
          state  <= RUN_WR;
          rd_q   <= 1'b0;
          wr_q   <= 1'b1;
          pad_q  <= 1'b0;
          addr_q <= OUT_BASE + {1'b0, idx};
        end
        RUN_WR: begin
          lfsr <= lfsr_nxt;
          if (idx == LAST_IDX) begin
            state  <= DONE;
            wr_q   <= 1'b0;
            pad_q  <= 1'b0;
            addr_q <= 8'd0;
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            idx    <= j_nxt;
            state  <= act_rd ? RUN_RD : RUN_WR;
            rd_q   <= act_rd;
            wr_q   <= ~act_rd;
            pad_q  <= ~act_rd;
            addr_q <= act_addr;
          end
        end
        DONE: begin
          if (bus.Start) begin
            ack_q <= 1'b0;
            armed <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_encrypt_seq.sv
// Scoreboard bench: each launch queues the 64 expected writes; a negedge monitor pops and compares.
module tb_msg_encrypt_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_encrypt_seq_if bus ();

  msg_encrypt_seq dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] dat;
  } wr_t;

  wr_t        q[$];
  logic [7:0] mem [0:255];
  logic [7:0] img [0:63];
  logic       ld_en   = 1'b0;
  logic [7:0] ld_addr = 8'd0;
  logic [7:0] ld_dat  = 8'd0;
  int         checks   = 0;
  int         failures = 0;
  int         rd_count = 0;
  int         wr_count = 0;

  logic [7:0] basic_exp [0:10] = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0,
                                   8'h41, 8'h03, 8'h06, 8'h0C, 8'h18};
  logic [7:0] tap_list  [0:8]  = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A,
                                   8'h69, 8'h5C, 8'h7E, 8'h7B};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Data memory: one-cycle read latency, write committed at the edge.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_dat;
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_rd_en) rd_count++;
    if (bus.mem_rd_en || bus.mem_wr_en)
      chk("rd_wr_exclusive", int'(bus.mem_rd_en & bus.mem_wr_en), 0);
    if (bus.mem_wr_en) begin
      wr_count++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", int'(bus.mem_addr), int'(e.addr));
        chk("wr_data", int'(bus.mem_wdata), int'(e.dat));
      end
    end
  end

  task automatic push_expected();
    logic [6:0] l, t, p, c;
    logic [7:0] b;
    int src;
    l = img[63][6:0];
    if (l == 7'd0) l = 7'h01;
    t = img[62][6:0];
    for (int j = 0; j < 64; j++) begin
      src = j - int'(img[61]);
      b = (src >= 0 && src < 61) ? img[src] : 8'h20;
      p = 7'(b - 8'h20);
      c = p ^ l;
      q.push_back('{addr: 8'(64 + j), dat: {^c, c}});
      l = {l[5:0], ^(l & t)};
    end
  endtask

  task automatic load();
    for (int a = 0; a < 64; a++) begin
      ld_en = 1'b1;
      ld_addr = 8'(a);
      ld_dat = img[a];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic set_basic();
    for (int a = 0; a < 61; a++) img[a] = 8'h20;
    img[61] = 8'd10;
    img[62] = 8'h60;
    img[63] = 8'h01;
  endtask

  task automatic run(input int exp_lat, input int exp_rd, input bit toggle,
                     input int rst_at, input int hold);
    int  n, rd0, wc;
    bit  had_ack, aborted;
    aborted = 1'b0;
    had_ack = bus.Ack;
    push_expected();
    rd0 = rd_count;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    if (had_ack) chk("ack_clear_on_start", int'(bus.Ack), 0);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("hold_no_launch", int'(bus.busy), 0);
    end
    bus.Start = 1'b0;
    @(posedge clk); #1;
    chk("busy_at_launch", int'(bus.busy), 1);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.Ack || n >= 400) break;
      @(posedge clk); #1;
      n++;
      if (n == rst_at) begin
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ack_after_abort", int'(bus.Ack), 0);
        chk("busy_after_abort", int'(bus.busy), 0);
        wc = wr_count;
        repeat (20) @(posedge clk);
        #1;
        chk("writes_after_abort", wr_count - wc, 0);
        chk("ack_idle_after_abort", int'(bus.Ack), 0);
        aborted = 1'b1;
        break;
      end
      if (toggle && n < exp_lat - 4) bus.Start = 1'($urandom_range(0, 1));
      else bus.Start = 1'b0;
    end
    if (!aborted) begin
      chk("ack_latency", n, exp_lat);
      chk("busy_at_done", int'(bus.busy), 0);
      chk("read_count", rd_count - rd0, exp_rd);
      chk("queue_drained", q.size(), 0);
    end
    q.delete();
  endtask

  initial begin
    int pre;
    bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", int'(bus.Ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rd_en", int'(bus.mem_rd_en), 0);
    chk("rst_wr_en", int'(bus.mem_wr_en), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_wdata", int'(bus.mem_wdata), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    set_basic();
    load();
    run(122, 57, 1'b0, 0, 0);
    for (int k = 0; k < 11; k++) chk("basic_byte", int'(mem[64 + k]), int'(basic_exp[k]));

    img[0] = 8'h41;
    load();
    run(122, 57, 1'b0, 0, 0);
    chk("single_char_74", int'(mem[74]), 8'h39);
    chk("single_char_73", int'(mem[73]), 8'h0C);

    img[0] = 8'h20;
    img[63] = 8'h00;
    load();
    run(122, 57, 1'b0, 0, 0);
    chk("zero_seed_64", int'(mem[64]), 8'h81);
    chk("zero_seed_70", int'(mem[70]), 8'h41);
    chk("zero_seed_74", int'(mem[74]), 8'h18);

    img[63] = 8'h01;
    img[61] = 8'hFF;
    load();
    run(68, 3, 1'b0, 0, 0);
    chk("full_pad_64", int'(mem[64]), 8'h81);
    chk("full_pad_74", int'(mem[74]), 8'h18);

    set_basic();
    load();
    run(122, 57, 1'b0, 30, 0);
    run(122, 57, 1'b0, 0, 0);
    chk("rerun_74", int'(mem[74]), 8'h18);

    run(122, 57, 1'b1, 0, 5);
    chk("toggle_run_70", int'(mem[70]), 8'h41);

    for (int t = 0; t < 9; t++) begin
      for (int a = 0; a < 61; a++) img[a] = 8'($urandom_range(32, 126));
      pre = int'($urandom_range(10, 15));
      img[61] = 8'(pre);
      img[62] = tap_list[t];
      img[63] = 8'($urandom_range(0, 255));
      load();
      run(68 + 64 - pre, 3 + 64 - pre, 1'b0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_encrypt_seq.md
Name: msg_encrypt_seq

Overview:
Hardware sequencer that performs Program #1 (LFSR message encryption) directly against data memory, without the instruction core.
- Reads config bytes at mem[61..63] and plaintext at mem[0..60].
- Writes 64 encrypted bytes with parity to mem[64..127], then raises Ack.
- Sits beside the core in TopLevel, muxed onto the DM1 port, and serves as the golden hardware reference for Program #1 runs.

Parameters:
CFG_PRE, 61, address of pre_length byte
CFG_TAP, 62, address of LFSR tap-pattern byte
CFG_SEED, 63, address of LFSR seed byte
OUT_BASE, 64, first output address
N_OUT, 64, encrypted bytes produced
MSG_MAX, 61, max readable plaintext bytes (mem[0..MSG_MAX-1])
PAD, 8'h20, ASCII space used for padding

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Start  in  1  1 = hold/arm; first cycle sampled 0 while armed launches a run
Ack  out  1  run complete; level
mem_addr  out  8  data memory address
mem_rd_en  out  1  read strobe; mem_rdata valid the following cycle
mem_rdata  in  8  read data
mem_wr_en  out  1  write strobe, committed at rising edge
mem_wdata  out  8  write data
busy  out  1  high from launch until Ack

Behaviour:
- Reset values: Ack=0, busy=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, armed=0, state=IDLE.
- Reset takes priority in every state. Mid-run reset aborts with no write in the reset cycle; already-written bytes remain.
- States:
  - IDLE: Start=1 sets armed. armed & Start=0 -> CFG. Start=0 with armed=0 stays in IDLE.
  - CFG: 4 cycles. Issue reads of 61, 62, 63 on consecutive cycles, capture each the following cycle. Then -> RUN with i=0.
  - RUN: for each output index i:
    - src = i - pre_len, computed 9-bit signed.
    - If 0 <= src < MSG_MAX: 2 cycles (read mem[src], then write).
    - Otherwise: 1 cycle (write, byte = PAD).
  - DONE: Ack=1, busy=0. Stays until Reset, or Start=1, which clears Ack, sets armed and goes to IDLE.
- Seed: a seed value of 0 is replaced by 7'h01. The seed is bit[6:0] of byte 63; taps are bit[6:0] of byte 62.
- Per byte i:
  - p = (byte - 8'h20)[6:0]
  - c = p ^ lfsr
  - mem_wdata = {^c, c}
  - mem_addr = OUT_BASE + i
- LFSR update after each write: lfsr <= {lfsr[5:0], ^(lfsr & taps)}. lfsr(0) = seed.
- pre_len uses all 8 bits. pre_len >= 64 means every byte is padding; no plaintext reads occur.
- Latency from launch cycle to Ack high = 4 + 64 + V, where V = number of valid src values = max(0, min(MSG_MAX, 64 - pre_len)) for pre_len <= 63. Example: pre_len=10 gives V=54, total 122 cycles.
- Start changes during CFG or RUN are ignored. mem_rd_en and mem_wr_en are never high in the same cycle.

Decomposition:
- Package msg_enc_pkg: address constants, PAD, N_OUT, MSG_MAX, and the state enum {IDLE, CFG, RUN_RD, RUN_WR, DONE}.
- Sub-module lfsr7_step: combinational next-state and parity helper {state, taps} -> {next, parity}, reusable by the core's ALU tests.

Test Plan:
- Basic run: mem[0..60]=8'h20, pre=10, taps=7'h60, seed=7'h01 -> mem[64..70]=81,82,84,88,90,A0,41; mem[71]=03; mem[74]=18; Ack after 122 cycles.
- Single character: mem[0]=8'h41 ('A'), otherwise the basic-run setup -> mem[74]=8'h39, all other bytes identical to the basic run.
- Zero seed: seed=0 -> output identical to seed=1.
- Full padding: pre=8'hFF -> no mem_rd_en after CFG; 64 writes; Ack after 68 cycles.
- Reset at cycle 30 of a run -> no further writes, Ack=0. Then Start 1->0 -> complete, correct rerun.
- Handshake: Start held 1 -> no launch. Start toggled during RUN -> ignored. Start=1 after DONE -> Ack falls the next cycle.
- Random sweep: random strings, each of the 9 tap patterns, random seed, pre 10..15 -> all 64 bytes match the bench model.
